// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
//
// Recovers pixel coordinates from an incoming VGA-style sync stream and
// verifies that its timing matches the expected H_TOTAL x V_TOTAL raster.
// Inputs are sampled only on pix_en cycles; every output is registered.
//
// Parameters
//   H_TOTAL     : pixel periods per line
//   V_TOTAL     : lines per frame
//   LOCK_FRAMES : consecutive good frames required before declaring lock
//
// Ports
//   Clk         : system clock (only clock)
//   Reset       : synchronous, active-high reset
//   pix_en      : pixel-rate enable; hs, vs and blank are sampled when high
//   hs, vs      : horizontal / vertical sync, active low
//   blank       : 1 = visible pixel, 0 = blanking
//   DrawX/DrawY : column / row of the current visible pixel (1 cycle latency)
//   active      : registered copy of the last sampled blank
//   locked      : timing verified against H_TOTAL / V_TOTAL
//   frame_start : one-cycle pulse on a correct vs fall while locked
//   line_err    : one-cycle pulse on a bad line length while locked
//   frame_err   : one-cycle pulse on a bad frame length while locked
//   err_count   : saturating count of line_err + frame_err events
// ---------------------------------------------------------------------------
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pix_en,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank,
    output logic [10:0] DrawX,
    output logic [10:0] DrawY,
    output logic        active,
    output logic        locked,
    output logic        frame_start,
    output logic        line_err,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [11:0] LP_H_TOTAL = H_TOTAL[11:0];
    localparam logic [9:0]  LP_V_TOTAL = V_TOTAL[9:0];
    localparam logic [7:0]  LP_LOCK    = LOCK_FRAMES[7:0];

    // Saturating increment helpers
    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Sample history (hs/vs preset high so reset never creates a fall)
    logic        r_hs_d;
    logic        r_vs_d;
    logic        r_active;
    logic [10:0] r_hcnt;
    logic [9:0]  r_vcnt;
    logic [10:0] r_draw_x;
    logic [10:0] r_draw_y;

    // Lock tracking state
    state_t      r_state;
    logic [7:0]  r_good;
    logic        r_line_valid;
    logic        r_frame_bad;
    logic        r_locked;
    logic        r_frame_start;
    logic        r_line_err;
    logic        r_frame_err;
    logic [7:0]  r_err_count;

    // Combinational next values
    state_t      w_state_nxt;
    logic [7:0]  w_good_nxt;
    logic        w_line_valid_nxt;
    logic        w_frame_bad_nxt;
    logic        w_locked_nxt;
    logic        w_fs_nxt;
    logic        w_le_nxt;
    logic        w_fe_nxt;
    logic [7:0]  w_err_count_nxt;

    logic        w_hs_fall;
    logic        w_vs_fall;
    logic        w_blank_rise;
    logic        w_blank_fall;
    logic [11:0] w_line_len;
    logic        w_line_bad;
    logic        w_line_chk_bad;
    logic [9:0]  w_vcnt_inc;
    logic        w_frame_len_bad;
    logic        w_bad_now;
    logic [7:0]  w_good_inc;

    assign w_hs_fall    = pix_en & r_hs_d & ~hs;
    assign w_vs_fall    = pix_en & r_vs_d & ~vs;
    assign w_blank_rise = pix_en & ~r_active & blank;
    assign w_blank_fall = pix_en & r_active & ~blank;

    // A saturated counter can never represent a legal length.
    assign w_line_len      = {1'b0, r_hcnt} + 12'd1;
    assign w_line_bad      = (r_hcnt == 11'h7FF) | (w_line_len != LP_H_TOTAL);
    assign w_line_chk_bad  = w_hs_fall & r_line_valid & w_line_bad;

    // The line ending in this sample is counted before the frame is judged,
    // so a simultaneous hs/vs fall still yields the full line count.
    assign w_vcnt_inc      = w_hs_fall ? sat_inc10(r_vcnt) : r_vcnt;
    assign w_frame_len_bad = (w_vcnt_inc == 10'h3FF) | (w_vcnt_inc != LP_V_TOTAL);
    assign w_bad_now       = r_frame_bad | w_line_chk_bad;
    assign w_good_inc      = r_good + 8'd1;

    // Lock state machine: next state, lock bookkeeping and pulse generation
    always_comb begin
        w_state_nxt      = r_state;
        w_good_nxt       = r_good;
        w_line_valid_nxt = r_line_valid;
        w_frame_bad_nxt  = r_frame_bad;
        w_locked_nxt     = r_locked;
        w_fs_nxt         = 1'b0;
        w_le_nxt         = 1'b0;
        w_fe_nxt         = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_vs_fall) begin
                    w_state_nxt      = ST_MEASURE;
                    w_good_nxt       = 8'd0;
                    w_line_valid_nxt = 1'b0;
                    w_frame_bad_nxt  = 1'b0;
                    w_locked_nxt     = 1'b0;
                end else begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_MEASURE: begin
                // The first line after SEARCH is partial and never judged.
                if (w_hs_fall) begin
                    w_line_valid_nxt = 1'b1;
                end else begin
                    w_line_valid_nxt = r_line_valid;
                end
                if (w_vs_fall) begin
                    w_frame_bad_nxt = 1'b0;
                    if (!w_bad_now && !w_frame_len_bad) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc >= LP_LOCK) begin
                            w_state_nxt  = ST_LOCKED;
                            w_locked_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_MEASURE;
                        end
                    end else begin
                        w_good_nxt = 8'd0;
                    end
                end else begin
                    w_frame_bad_nxt = w_bad_now;
                end
            end
            ST_LOCKED: begin
                if (w_line_chk_bad) begin
                    // The broken frame must not count towards relock unless
                    // it ends in this very sample.
                    w_le_nxt         = 1'b1;
                    w_state_nxt      = ST_MEASURE;
                    w_good_nxt       = 8'd0;
                    w_locked_nxt     = 1'b0;
                    w_line_valid_nxt = 1'b1;
                    w_frame_bad_nxt  = ~w_vs_fall;
                end else if (w_vs_fall) begin
                    if (w_frame_len_bad) begin
                        w_fe_nxt        = 1'b1;
                        w_state_nxt     = ST_MEASURE;
                        w_good_nxt      = 8'd0;
                        w_locked_nxt    = 1'b0;
                        w_frame_bad_nxt = 1'b0;
                    end else begin
                        w_fs_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            default: begin
                w_state_nxt      = ST_SEARCH;
                w_good_nxt       = 8'd0;
                w_line_valid_nxt = 1'b0;
                w_frame_bad_nxt  = 1'b0;
                w_locked_nxt     = 1'b0;
            end
        endcase
    end

    // Error counter saturates instead of wrapping
    always_comb begin
        if (w_le_nxt || w_fe_nxt) begin
            w_err_count_nxt = sat_inc8(r_err_count);
        end else begin
            w_err_count_nxt = r_err_count;
        end
    end

    // Sample history, raster counters and pixel coordinates
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hs_d   <= 1'b1;
            r_vs_d   <= 1'b1;
            r_active <= 1'b0;
            r_hcnt   <= 11'd0;
            r_vcnt   <= 10'd0;
            r_draw_x <= 11'd0;
            r_draw_y <= 11'd0;
        end else if (pix_en) begin
            r_hs_d   <= hs;
            r_vs_d   <= vs;
            r_active <= blank;
            r_hcnt   <= w_hs_fall ? 11'd0 : sat_inc11(r_hcnt);
            r_vcnt   <= w_vs_fall ? 10'd0 : w_vcnt_inc;
            if (w_blank_rise) begin
                r_draw_x <= 11'd0;
            end else if (blank && r_active) begin
                r_draw_x <= r_draw_x + 11'd1;
            end else begin
                r_draw_x <= r_draw_x;
            end
            if (w_vs_fall) begin
                r_draw_y <= 11'd0;
            end else if (w_blank_fall) begin
                r_draw_y <= r_draw_y + 11'd1;
            end else begin
                r_draw_y <= r_draw_y;
            end
        end else begin
            r_hs_d   <= r_hs_d;
            r_vs_d   <= r_vs_d;
            r_active <= r_active;
            r_hcnt   <= r_hcnt;
            r_vcnt   <= r_vcnt;
            r_draw_x <= r_draw_x;
            r_draw_y <= r_draw_y;
        end
    end

    // Lock state, status flags and one-cycle pulses
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= ST_SEARCH;
            r_good        <= 8'd0;
            r_line_valid  <= 1'b0;
            r_frame_bad   <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_err    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_err_count   <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_good        <= w_good_nxt;
            r_line_valid  <= w_line_valid_nxt;
            r_frame_bad   <= w_frame_bad_nxt;
            r_locked      <= w_locked_nxt;
            r_frame_start <= w_fs_nxt;
            r_line_err    <= w_le_nxt;
            r_frame_err   <= w_fe_nxt;
            r_err_count   <= w_err_count_nxt;
        end
    end

    assign DrawX       = r_draw_x;
    assign DrawY       = r_draw_y;
    assign active      = r_active;
    assign locked      = r_locked;
    assign frame_start = r_frame_start;
    assign line_err    = r_line_err;
    assign frame_err   = r_frame_err;
    assign err_count   = r_err_count;

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
- Parameters:
  - REQ-001 SHALL provide parameter H_TOTAL, default 800, pixel periods per line.
  - REQ-002 SHALL provide parameter V_TOTAL, default 525, lines per frame.
  - REQ-003 SHALL provide parameter LOCK_FRAMES, default 2, consecutive good frames required to lock.
- Ports:
  - REQ-004 SHALL have port Clk  input  1  system clock, the only clock.
  - REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
  - REQ-006 SHALL have port pix_en  input  1  pixel-rate enable; hs, vs and blank are sampled only when pix_en=1.
  - REQ-007 SHALL have port hs  input  1  horizontal sync, active low.
  - REQ-008 SHALL have port vs  input  1  vertical sync, active low.
  - REQ-009 SHALL have port blank  input  1  active-low blanking (1 = visible pixel).
  - REQ-010 SHALL have port DrawX  output  11  column index of the current visible pixel.
  - REQ-011 SHALL have port DrawY  output  11  row index of the current visible line.
  - REQ-012 SHALL have port active  output  1  registered copy of the last sampled blank.
  - REQ-013 SHALL have port locked  output  1  timing verified against H_TOTAL/V_TOTAL.
  - REQ-014 SHALL have port frame_start  output  1  one-Clk pulse on vs falling edge while locked.
  - REQ-015 SHALL have ports line_err and frame_err  output  1 each  one-Clk error pulses.
  - REQ-016 SHALL have port err_count  output  8  saturating count of line_err plus frame_err events.

Function
- Edge detection:
  - REQ-017 SHALL register hs/vs/blank on each pix_en sample; a fall is previous=1, current=0; a blank rise is previous=0, current=1.
  - REQ-018 SHALL hold all counters, state and outputs when pix_en=0; the one-cycle pulses are the exception and SHALL deassert.
- Horizontal counting:
  - REQ-019 SHALL count pix_en samples in hcnt (11 bits, saturating at 2047).
  - REQ-020 SHALL, on an hs fall, take line length = hcnt+1 and then clear hcnt.
- Vertical counting:
  - REQ-021 SHALL increment vcnt (10 bits, saturating at 1023) on each hs fall.
  - REQ-022 SHALL, on a vs fall, take frame length = vcnt and then clear vcnt.
- Coordinates:
  - REQ-023 SHALL clear DrawX on a blank rise and increment it on each later visible sample.
  - REQ-024 SHALL increment DrawY on a blank fall that ends a visible run, and clear DrawY on a vs fall.
  - REQ-025 SHALL update DrawX/DrawY one Clk after the sample; latency is 1 cycle.
- State machine: states SEARCH, MEASURE, LOCKED.
  - REQ-026 SEARCH: wait for the first vs fall, then go to MEASURE with good=0 and line_valid=0.
  - REQ-027 MEASURE: line_valid goes to 1 at the first hs fall; each hs fall with line_valid=1 and line length != H_TOTAL marks the frame bad.
  - REQ-028 MEASURE, on a vs fall: a good frame (no bad line and frame length == V_TOTAL) increments good; a bad frame clears good.
  - REQ-029 MEASURE: when good reaches LOCK_FRAMES, go to LOCKED and set locked=1 on that same vs-fall cycle.
  - REQ-030 LOCKED, line length != H_TOTAL: pulse line_err, go to MEASURE, clear good and locked, keep line_valid=1.
  - REQ-031 LOCKED, frame length != V_TOTAL at a vs fall: pulse frame_err, go to MEASURE, clear good and locked.
  - REQ-032 LOCKED, correct frame: pulse frame_start on the vs-fall cycle.
- Boundary conditions:
  - REQ-033 SHALL, when hs and vs fall in the same sample, complete line processing first and count that line in vcnt before the frame check.
  - REQ-034 SHALL NOT check line length for the first hs fall after SEARCH; this line is partial.
  - REQ-035 SHALL hold err_count at 255 and SHALL NOT wrap.
  - REQ-036 SHALL, on a saturated hcnt or vcnt, treat the resulting length as a mismatch.
  - REQ-037 SHALL hold DrawX/DrawY at their last values during blanking.

Reset
- REQ-038 SHALL, with Reset=1 at a Clk edge, go to SEARCH and clear hcnt, vcnt, good, line_valid, DrawX, DrawY, active, locked, frame_start, line_err, frame_err and err_count.
- REQ-039 SHALL preset the sampled hs/vs history to 1 so that no spurious fall is detected after reset.
- REQ-040 SHALL let Reset override pix_en and all events in the same cycle, and SHALL behave identically when reset mid-frame.

Verification
- REQ-041 Three nominal 800x525 frames from a 640x480 source, pix_en every 2nd Clk -> locked=1 at the 3rd vs fall; frame_start pulses from then on; DrawX runs 0..639 and DrawY 0..479.
- REQ-042 While locked, one line of 801 pixels -> one line_err pulse at that hs fall, locked=0, err_count=1; relock after 2 more clean frames.
- REQ-043 While locked, one frame of 524 lines -> frame_err pulse at the vs fall, locked=0, no frame_start on that edge.
- REQ-044 hs and vs fall in the same sample -> that line is counted in vcnt; a 525-line frame passes.
- REQ-045 300 injected errors -> err_count holds at 255.
- REQ-046 Reset asserted for 1 cycle mid-frame while locked -> all outputs 0 next cycle; the first post-reset partial line raises no line_err.
